// File: rtl/lane_merge_pkg.sv
// Shared types and constants for the lane merge FIFO block.
// Provides the merger FSM state encoding and the lane-index width helper.
// Optional per-lane statistics are enabled with the LANE_MERGE_STATS_EN macro.
package lane_merge_pkg;

   typedef enum logic [1:0] {
      LM_IDLE   = 2'd0,
      LM_ACTIVE = 2'd1,
      LM_FLUSH  = 2'd2
   } lm_state_t;

   localparam int LM_DEFAULT_WIDTH = 16;
   localparam int LM_DEFAULT_DEPTH = 8;

   // Width of a lane index; a single lane still gets a 1-bit tag.
   function automatic int lane_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single-lane synchronous FIFO, count-based, power-of-two depth.
// Latency: a written word is readable the cycle after the write (no bypass).
// Backpressure: full/empty come straight from the registered count.
module lane_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   // A write while full is allowed only when a pop frees the slot in the same cycle.
   assign do_wr = wr_en && (!full || rd_en);
   assign do_rd = rd_en && !empty;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Pointers and occupancy; clr wipes the queue regardless of any request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_wr && !clr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/lane_merge_fifo.sv
// Per-lane FIFO buffering with round-robin merge into one registered, lane-tagged stream.
// Latency: word accepted at edge N appears on out_* after edge N+1 when it wins arbitration.
// Backpressure: in_ready = lane not full and not flushing; out_valid && !out_ready holds output.
// Optional per-lane accepted-write counters when LANE_MERGE_STATS_EN is defined.
module lane_merge_fifo
   import lane_merge_pkg::*;
#(
   parameter  int NUM_LANES = 2,
   parameter  int WIDTH     = LM_DEFAULT_WIDTH,
   parameter  int DEPTH     = LM_DEFAULT_DEPTH,
   localparam int LANE_W    = lane_w(NUM_LANES)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic [NUM_LANES-1:0]            in_valid,
   output logic [NUM_LANES-1:0]            in_ready,
   input  logic [NUM_LANES-1:0][WIDTH-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [WIDTH-1:0]                out_data,
   output logic [LANE_W-1:0]               out_lane,
   output logic                            busy
`ifdef LANE_MERGE_STATS_EN
   ,
   output logic [NUM_LANES-1:0][15:0]      stat_count
`endif
);

   lm_state_t state;
   lm_state_t state_nxt;

   logic [NUM_LANES-1:0]            fifo_full;
   logic [NUM_LANES-1:0]            fifo_empty;
   logic [NUM_LANES-1:0][WIDTH-1:0] fifo_rd;
   logic [NUM_LANES-1:0]            wr_en;
   logic [NUM_LANES-1:0]            rd_en;
   logic [LANE_W-1:0]               rr;
   logic [LANE_W-1:0]               sel;
   logic                            found;
   logic                            load;

   // Flush wins over writes: a word presented in the flush cycle is dropped.
   assign wr_en = in_valid & in_ready & {NUM_LANES{!flush}};
   assign load  = !flush && found && (!out_valid || out_ready);

   genvar l;
   generate
      for (l = 0; l < NUM_LANES; l++) begin : gen_lane
         assign rd_en[l] = load && (sel == LANE_W'(l));

         lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .clr     (flush),
            .wr_en   (wr_en[l]),
            .wr_data (in_data[l]),
            .rd_en   (rd_en[l]),
            .rd_data (fifo_rd[l]),
            .full    (fifo_full[l]),
            .empty   (fifo_empty[l])
         );
      end
   endgenerate

   // Round-robin pick: first non-empty lane starting just after the last one served.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      for (int off = 1; off <= NUM_LANES; off++) begin
         if (!found && !fifo_empty[(int'(rr) + off) % NUM_LANES]) begin
            found = 1'b1;
            sel   = LANE_W'((int'(rr) + off) % NUM_LANES);
         end
      end
   end

   // Arbitration pointer; reset/flush park it on the last lane so lane 0 goes first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rr <= LANE_W'(NUM_LANES - 1);
      else if (flush) rr <= LANE_W'(NUM_LANES - 1);
      else if (load)  rr <= sel;
   end

   // Output register: load the winner when free, drop valid when nothing is buffered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_lane  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
         if (found) begin
            out_valid <= 1'b1;
            out_data  <= fifo_rd[sel];
            out_lane  <= sel;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LM_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state: go idle once the last buffered word has left the output register.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = LM_FLUSH;
      end else begin
         case (state)
            LM_IDLE:   if (|wr_en) state_nxt = LM_ACTIVE;
            LM_ACTIVE: if (!found && (!out_valid || out_ready) && !(|wr_en))
                          state_nxt = LM_IDLE;
            LM_FLUSH:  state_nxt = LM_IDLE;
            default:   state_nxt = LM_IDLE;
         endcase
      end
   end

   // FSM outputs: ready and busy derive only from registered state and counts.
   always_comb begin
      in_ready = ~fifo_full & {NUM_LANES{state != LM_FLUSH}};
      busy     = !(&fifo_empty) || out_valid;
   end

`ifdef LANE_MERGE_STATS_EN
   // Saturating per-lane count of accepted writes, cleared by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_count <= '0;
      end else if (flush) begin
         stat_count <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (wr_en[i] && stat_count[i] != 16'hFFFF)
               stat_count[i] <= stat_count[i] + 16'd1;
         end
      end
   end
`endif

endmodule
